// File: rtl/tl_memory_controller_master.sv
// TileLink-UL master bridge: one CPU load/store at a time becomes a channel-A
// Get / PutFullData / PutPartialData, and the channel-D reply becomes a
// one-cycle CPU response.
// Optional macro TL_MEMORY_CONTROLLER_MASTER_TIMEOUT_EN adds a WAIT_D timeout
// and drains stray D beats while idle.
module tl_memory_controller_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SIZE_W         = 2,
  parameter int unsigned SOURCE_W       = 1,
  parameter int unsigned SOURCE_ID      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_error,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [2:0]            a_opcode,
  output logic [2:0]            a_param,
  output logic [SIZE_W-1:0]     a_size,
  output logic [SOURCE_W-1:0]   a_source,
  output logic [ADDR_W-1:0]     a_address,
  output logic [DATA_W/8-1:0]   a_mask,
  output logic [DATA_W-1:0]     a_data,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [2:0]            d_opcode,
  input  logic [1:0]            d_param,
  input  logic [SIZE_W-1:0]     d_size,
  input  logic [SOURCE_W-1:0]   d_source,
  input  logic [DATA_W-1:0]     d_data,
  input  logic                  d_error
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam logic [2:0] OpGet = 3'd4, OpPutFull = 3'd0, OpPutPartial = 3'd1;
  localparam logic [2:0] OpAccessAck = 3'd0, OpAccessAckData = 3'd1;

  typedef enum logic [1:0] {StIdle, StSendA, StWaitD, StRespond} state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          a_opcode_q, a_opcode_d;
  logic [MaskW-1:0]    a_mask_q, a_mask_d;
  logic [DATA_W-1:0]   a_data_q, a_data_d;
  logic                req_ready_q, req_ready_d;
  logic                a_valid_q, a_valid_d;
  logic                d_ready_q, d_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;

  logic                misaligned;
  logic [MaskW-1:0]    req_mask;
  logic [DATA_W-1:0]   req_lanes;
  logic [DATA_W-1:0]   load_data;
  logic                d_match;

`ifdef TL_MEMORY_CONTROLLER_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // d_param and d_size carry nothing the bridge needs to check
  logic unused_inputs;
  assign unused_inputs = ^{d_param, d_size, TIMEOUT_CYCLES[0]};

  assign d_match = d_valid && d_ready_q && (d_source == SOURCE_W'(SOURCE_ID));

  // Lane/mask generation and alignment check for the incoming CPU request
  always_comb begin
    misaligned = 1'b0;
    req_mask   = '0;
    req_lanes  = req_wdata;
    unique case (req_size)
      2'd0: begin
        req_mask  = MaskW'(1) << req_addr[1:0];
        req_lanes = {(DATA_W/8){req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = req_addr[0];
        req_mask   = MaskW'(3) << {req_addr[1], 1'b0};
        req_lanes  = {(DATA_W/16){req_wdata[15:0]}};
      end
      2'd2: begin
        misaligned = (req_addr[1:0] != 2'b00);
        req_mask   = '1;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Right-align the addressed lanes of a D beat and zero-extend to the access size
  always_comb begin
    load_data = d_data >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'd0:    load_data = load_data & DATA_W'(32'h0000_00ff);
      2'd1:    load_data = load_data & DATA_W'(32'h0000_ffff);
      default: load_data = load_data;
    endcase
  end

  // Next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    addr_d       = addr_q;
    a_opcode_d   = a_opcode_q;
    a_mask_d     = a_mask_q;
    a_data_d     = a_data_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
`ifdef TL_MEMORY_CONTROLLER_MASTER_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          addr_d   = req_addr;
          a_mask_d = req_mask;
          a_data_d = req_write ? req_lanes : '0;
          if (!req_write)            a_opcode_d = OpGet;
          else if (&req_mask)        a_opcode_d = OpPutFull;
          else                       a_opcode_d = OpPutPartial;
          if (misaligned) begin
            state_d      = StRespond;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = StSendA;
          end
        end
      end
      StSendA: begin
        if (a_ready) begin
          state_d = StWaitD;
`ifdef TL_MEMORY_CONTROLLER_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWaitD: begin
        // Beats from other sources are accepted (d_ready high) and dropped
        if (d_match) begin
          state_d      = StRespond;
          resp_error_d = d_error ||
                         (d_opcode != (write_q ? OpAccessAck : OpAccessAckData));
          resp_rdata_d = write_q ? '0 : load_data;
        end
`ifdef TL_MEMORY_CONTROLLER_MASTER_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d      = StRespond;
          resp_error_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    req_ready_d  = (state_d == StIdle);
    a_valid_d    = (state_d == StSendA);
    resp_valid_d = (state_d == StRespond);
`ifdef TL_MEMORY_CONTROLLER_MASTER_TIMEOUT_EN
    d_ready_d    = (state_d == StWaitD) || (state_d == StIdle);
`else
    d_ready_d    = (state_d == StWaitD);
`endif
  end

  // State and registered outputs; synchronous reset abandons any transaction
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      a_opcode_q   <= '0;
      a_mask_q     <= '0;
      a_data_q     <= '0;
      req_ready_q  <= 1'b1;
      a_valid_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
`ifdef TL_MEMORY_CONTROLLER_MASTER_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      a_opcode_q   <= a_opcode_d;
      a_mask_q     <= a_mask_d;
      a_data_q     <= a_data_d;
      req_ready_q  <= req_ready_d;
      a_valid_q    <= a_valid_d;
      d_ready_q    <= d_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
`ifdef TL_MEMORY_CONTROLLER_MASTER_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign a_valid    = a_valid_q;
  assign d_ready    = d_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign a_opcode   = a_opcode_q;
  assign a_param    = 3'b000;
  assign a_size     = SIZE_W'(size_q);
  assign a_source   = SOURCE_W'(SOURCE_ID);
  assign a_address  = addr_q;
  assign a_mask     = a_mask_q;
  assign a_data     = a_data_q;

endmodule
